// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: control opcodes, FSM states and
// the sequential fetch increment.
package decode_pkg;

  localparam int PC_STEP = 4;

  localparam logic [3:0] OP_HALT = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_BRZ  = 4'hF;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } state_e;

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register: instruction word, its address and a valid flag,
// updated only when load is high.
module ifid_register #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [INSTR_W-1:0] next_instr,
  input  logic [ADDR_W-1:0]  next_pc,
  input  logic               next_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic               valid
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= next_instr;
      pc    <= next_pc;
      valid <= next_valid;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: owns the IF/ID register, tracks the fetch PC and redirects
// fetch for boot, stall, HALT and taken JMP/BRZ.
module decode_stage #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter int                PC_STEP  = decode_pkg::PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               stall,
  input  logic               zeroFlag,
  output logic               pcWrEn,
  output logic [ADDR_W-1:0]  newPc,
  output logic               idValid,
  output logic [ADDR_W-1:0]  idPc,
  output logic [3:0]         opcode,
  output logic [3:0]         rd,
  output logic [3:0]         rs1,
  output logic [3:0]         rs2,
  output logic [7:0]         imm8,
  output logic               halted
);

  import decode_pkg::*;

  state_e              state;
  logic [ADDR_W-1:0]   fetch_pc_shadow;
  logic [ADDR_W-1:0]   next_pc;
  logic [ADDR_W-1:0]   id_pc_q;
  logic [INSTR_W-1:0]  id_instr;
  logic                id_valid_q;
  logic                ifid_load;
  logic [3:0]          id_op;
  logic                live;
  logic                halt_req;
  logic                redirect;

  assign id_op = id_instr[15:12];

  // A control instruction is only acted on while running and not stalled.
  assign live     = id_valid_q && (state == ST_RUN) && !stall;
  assign halt_req = live && (id_op == OP_HALT);
  assign redirect = live && ((id_op == OP_JMP) || ((id_op == OP_BRZ) && zeroFlag));

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    pcWrEn    = 1'b1;
    newPc     = fetch_pc_shadow;
    ifid_load = 1'b0;
    case (state)
      ST_BOOT: begin
        newPc     = RESET_PC;
        ifid_load = 1'b1;
      end
      ST_RUN: begin
        // Stall and HALT both pin fetch to its current address and freeze IF/ID.
        if (!stall && !halt_req) begin
          ifid_load = 1'b1;
          if (redirect) begin
            newPc = ADDR_W'(id_instr[7:0]);
          end else begin
            pcWrEn = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  assign next_pc = pcWrEn ? newPc : fetch_pc_shadow + ADDR_W'(PC_STEP);

  ifid_register #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_ifid (
    .clk        (clk),
    .rst_n      (reset),
    .load       (ifid_load),
    .next_instr (instruction),
    .next_pc    (next_pc),
    .next_valid (1'b1),
    .instr      (id_instr),
    .pc         (id_pc_q),
    .valid      (id_valid_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_BOOT;
      fetch_pc_shadow <= RESET_PC;
      halted          <= 1'b0;
    end else begin
      fetch_pc_shadow <= next_pc;
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (halt_req) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign idValid = id_valid_q && !halted;
  assign idPc    = id_pc_q;
  assign opcode  = id_op;
  assign rd      = id_instr[11:8];
  assign rs1     = id_instr[7:4];
  assign rs2     = id_instr[3:0];
  assign imm8    = id_instr[7:0];

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: ADDR_W, 8, program-counter width in bits.
REQ-002 Parameter: INSTR_W, 16, instruction width in bits.
REQ-003 Parameter: PC_STEP, 4, sequential PC increment (matches fetch stage).
REQ-004 Parameter: RESET_PC, 0, first instruction address after reset.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 instruction  in  16  fetch-stage ROM output for the address fetch is loading this cycle.
REQ-008 stall  in  1  downstream hazard; hold IF/ID and freeze fetch.
REQ-009 zeroFlag  in  1  condition for BRZ, valid in the same cycle.
REQ-010 pcWrEn  out  1  fetch PC override enable (combinational).
REQ-011 newPc  out  8  fetch PC override value (combinational).
REQ-012 idValid  out  1  IF/ID holds a live instruction.
REQ-013 idPc  out  8  address of the IF/ID instruction.
REQ-014 opcode/rd/rs1/rs2  out  4 each  fields [15:12]/[11:8]/[7:4]/[3:0] of the IF/ID instruction.
REQ-015 imm8  out  8  field [7:0] of the IF/ID instruction.
REQ-016 halted  out  1  HALT state reached.

Function
REQ-017 The block SHALL keep fetchPcShadow mirroring the fetch PC register: each edge it loads nextPc = pcWrEn ? newPc : fetchPcShadow + PC_STEP, modulo 2^ADDR_W (0xFC+4 = 0x00).
REQ-018 FSM states SHALL be BOOT, RUN, HALT; BOOT lasts exactly one cycle after reset deassertion, then RUN.
REQ-019 In BOOT: pcWrEn=1, newPc=RESET_PC; at the edge IF/ID captures instruction with idPc=RESET_PC, idValid=1.
REQ-020 In RUN without stall: IF/ID captures instruction, idPc<=nextPc, idValid<=1 each edge.
REQ-021 JMP (opcode 4'hE) valid in IF/ID SHALL drive pcWrEn=1, newPc=imm8 in the same cycle; zero-bubble redirect, fall-through instruction never becomes valid.
REQ-022 BRZ (opcode 4'hF) SHALL behave as JMP when zeroFlag=1; otherwise pcWrEn=0.
REQ-023 stall=1 SHALL hold all IF/ID outputs stable and drive pcWrEn=1, newPc=fetchPcShadow; a branch or HALT in IF/ID is acted on only once stall is low.
REQ-024 Priority: reset > stall > HALT > JMP/BRZ > sequential.
REQ-025 HALT (opcode 4'hD) valid in IF/ID without stall SHALL move to HALT at the next edge.
REQ-026 In HALT: halted=1, idValid=0, pcWrEn=1, newPc=fetchPcShadow, IF/ID frozen; exit only via reset.
REQ-027 Non-control opcodes SHALL pass fields through unmodified with pcWrEn=0.

Reset
REQ-028 While reset=0: state=BOOT, fetchPcShadow=RESET_PC, idValid=0, idPc=0, opcode/rd/rs1/rs2/imm8=0, halted=0; consequently pcWrEn=1, newPc=RESET_PC.
REQ-029 Reset asserted mid-operation (including HALT or stall) SHALL discard IF/ID contents immediately, with no glitch-dependent output.

Structure
REQ-030 A shared package decode_pkg SHALL hold opcode constants OP_HALT=4'hD, OP_JMP=4'hE, OP_BRZ=4'hF, the FSM state enum, and PC_STEP.
REQ-031 One sub-module, ifid_register (instruction, pc, valid with load-enable and async active-low reset), SHALL implement the pipeline register; FSM, shadow PC and redirect logic live in decode_stage.
REQ-032 Expected size: 150-250 lines RTL.

Verification
REQ-033 Reset release, rom[0]=0x1234 -> BOOT cycle pcWrEn=1, newPc=0x00; next cycle idValid=1, idPc=0x00, opcode=1, rd=2, rs1=3, rs2=4.
REQ-034 JMP 0xE040 at idPc=0x08 -> same cycle pcWrEn=1, newPc=0x40; next cycle idPc=0x40; address 0x0C never seen with idValid=1.
REQ-035 BRZ 0xF020 at 0x10: zeroFlag=0 -> pcWrEn=0, next idPc=0x14; zeroFlag=1 -> newPc=0x20, next idPc=0x20.
REQ-036 stall high 3 cycles at idPc=0x18 -> outputs constant, pcWrEn=1, newPc=0x18 each cycle; after release idPc sequence 0x1C, 0x20 (no skip, no duplicate).
REQ-037 HALT 0xD000 at 0x30 -> next cycle halted=1, idValid=0, newPc constant for 10 cycles; reset pulse -> BOOT, idPc=0x00.
REQ-038 Sequential run through 0xFC -> next idPc=0x00 (wrap-around).
